camo_cell_array: RTL and testbench
==================================

// Module: camo_cell_array
// PURPOSE
// - Parametrised array of NCELL camouflaged 2-input cells; each cell is NAND, NOR or XOR, selected by a 2-bit key slice.
// - Generalises the fixed, key-pin-driven camouflaged gates used in the obfuscated ISCAS netlists.
// - Adds a serial key-load port with a parity check, a load/arm state machine and a registered datapath.
// - Sits between the key-delivery logic and the obfuscated combinational cores.
// PARAMETERS
// - NCELL   8           number of camouflaged cells (1..64)
// - KEY_W   2*NCELL     key length in bits (derived; do not override)
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      asynchronous reset, active-high
// - key_start  in   1      pulse: begin a (re)load; accepted in any state except during reset
// - key_valid  in   1      serial key bit is valid this cycle
// - key_ready  out  1      block accepts key_bit this cycle (high only in LOAD)
// - key_bit    in   1      serial key data, LSB (key[0]) first, parity bit last
// - key_last   in   1      marks the final (parity) bit of a transfer
// - in_valid   in   1      operands valid
// - a          in   NCELL  operand A, one bit per cell
// - b          in   NCELL  operand B, one bit per cell
// - out_valid  out  1      y valid
// - y          out  NCELL  cell outputs, registered
// - armed      out  1      key loaded and parity-checked; datapath live
// - key_err    out  1      last load failed; sticky until next key_start or reset
// BEHAVIOUR
// - Reset (async): state=IDLE, key register=0, bit counter=0, key_ready=0, out_valid=0, y=0, armed=0, key_err=0.
// - Cell i function from s0=key[2i], s1=key[2i+1]: s0=1 -> XOR (s1 ignored); s0=0,s1=0 -> NAND; s0=0,s1=1 -> NOR.
// - FSM states: IDLE, LOAD, CHECK, ARMED, ERROR.
//   - IDLE: key_ready=0. key_start -> LOAD.
//   - LOAD: key_ready=1. Each key_valid cycle shifts one bit: counts 0..KEY_W-1 fill key[cnt]; count KEY_W is the parity bit.
//     key_valid with key_last on count KEY_W -> CHECK. key_last on any other count -> ERROR.
//     Parity bit (count KEY_W) without key_last -> ERROR. key_valid=0 cycles stall without timeout.
//   - CHECK: one cycle. Even parity over key[KEY_W-1:0] ^ parity bit must be 0. Pass -> ARMED, armed=1. Fail -> ERROR.
//   - ARMED: armed=1; datapath enabled. key_start -> LOAD.
//   - ERROR: key_err=1, armed=0. key_start -> LOAD.
// - Any key_start: clears armed, key_err, counter and key register the same cycle. The block enters LOAD next cycle.
//   key_start wins over a coincident key_valid; that bit is discarded.
// - key_start in LOAD restarts the transfer from count 0.
// - Datapath: in ARMED, y <= f(a,b) and out_valid <= in_valid, so latency is 1 cycle. y holds its value when in_valid=0.
// - Outside ARMED: out_valid=0 and y=0 from the cycle after armed falls. An operand accepted in the last ARMED cycle still emits.
// - The key register is never readable from ports. The cell function changes only when entering ARMED.
// TESTING
// - Load key=0x0000, parity=0 (NCELL=8); then a=0xF0, b=0xCC -> after CHECK: armed=1; one cycle after in_valid: y=0x3F (all NAND), out_valid=1.
// - Load key=0xAAAA, parity=0; a=0xF0, b=0xCC -> y=0x03 (all NOR).
// - Load key=0x5555, parity=0 -> y=0x3C (all XOR). Mixed key 0x0012 (cell0 NOR, cell2 XOR, rest NAND) -> check per bit.
// - Load key=0x5555 with parity=1 -> key_err=1, armed=0, out_valid stays 0, y=0. A new key_start clears key_err.
// - key_last on bit 7 -> ERROR. A 17th bit without key_last -> ERROR. key_valid gaps of 5 cycles mid-load -> load still succeeds.
// - Assert rst in LOAD and in ARMED: all outputs are 0 immediately (async). key_start while ARMED with in_valid high -> out_valid drops next cycle.

Source files
------------

// File: rtl/camo_cell_array.sv
// ---------------------------------------------------------------------------
// camo_cell_array
//
// Purpose:
//   Array of NCELL camouflaged 2-input cells. Each cell computes NAND, NOR or
//   XOR of its operand bits. A 2-bit key slice selects the function. The key
//   arrives through a serial load port. The last bit of a transfer is an even
//   parity bit. A small FSM loads the key, checks it and then arms the
//   registered datapath. The key itself never leaves the block.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   key_start  in   1      pulse: begin a (re)load of the key
//   key_valid  in   1      key_bit is valid this cycle
//   key_ready  out  1      block accepts key_bit this cycle (LOAD only)
//   key_bit    in   1      serial key data, key[0] first, parity bit last
//   key_last   in   1      marks the parity bit, the last bit of a transfer
//   in_valid   in   1      operands valid
//   a          in   NCELL  operand A, one bit per cell
//   b          in   NCELL  operand B, one bit per cell
//   out_valid  out  1      y valid (one cycle after in_valid while armed)
//   y          out  NCELL  registered cell outputs
//   armed      out  1      key loaded and parity-checked; datapath live
//   key_err    out  1      last load failed; held until key_start or reset
// ---------------------------------------------------------------------------
module camo_cell_array #(
    parameter int NCELL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             key_bit,
    input  logic             key_last,
    input  logic             in_valid,
    input  logic [NCELL-1:0] a,
    input  logic [NCELL-1:0] b,
    output logic             out_valid,
    output logic [NCELL-1:0] y,
    output logic             armed,
    output logic             key_err
);

    localparam int KEY_W = 2 * NCELL;
    localparam int CNT_W = $clog2(KEY_W + 1);
    // The count value at which the parity bit is expected.
    localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(KEY_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ARMED,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q,   key_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               par_q,   par_d;
    logic [NCELL-1:0]   y_q,     y_d;
    logic               out_valid_q, out_valid_d;
    logic [NCELL-1:0]   cell_f;

    // ------------------------------------------------------------------
    // Key load / check FSM (next-state and key shift register)
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        par_d   = par_q;

        if (key_start) begin
            // A restart wins over everything, including a coincident
            // key_valid. That bit is dropped.
            state_d = S_LOAD;
            key_d   = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    if (key_valid) begin
                        if (cnt_q == PAR_CNT) begin
                            // Parity slot: this bit must be the last one.
                            par_d   = key_bit;
                            state_d = key_last ? S_CHECK : S_ERROR;
                        end else if (key_last) begin
                            // The transfer ended before the parity slot.
                            state_d = S_ERROR;
                        end else begin
                            key_d = key_q | ({{(KEY_W-1){1'b0}}, key_bit} << cnt_q);
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                // Even parity: the key bits and the parity bit XOR to zero.
                S_CHECK: state_d = (^{key_q, par_q}) ? S_ERROR : S_ARMED;
                S_ARMED: ;
                S_ERROR: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Camouflaged cells: s0 = key[2i] selects XOR; otherwise s1 = key[2i+1]
    // selects NOR (1) or NAND (0).
    // ------------------------------------------------------------------
    always_comb begin
        cell_f = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (key_q[2*i])
                cell_f[i] = a[i] ^ b[i];
            else if (key_q[2*i+1])
                cell_f[i] = ~(a[i] | b[i]);
            else
                cell_f[i] = ~(a[i] & b[i]);
        end
    end

    // ------------------------------------------------------------------
    // Datapath. It runs only in ARMED. The key cannot change while ARMED,
    // because any key_start leaves ARMED first, so the cell function is
    // fixed for the whole armed period. The cycle after ARMED is left,
    // the operand taken in the last armed cycle is still presented.
    // After that cycle the outputs are forced to zero.
    // ------------------------------------------------------------------
    always_comb begin
        y_d         = y_q;
        out_valid_d = 1'b0;
        if (state_q == S_ARMED) begin
            out_valid_d = in_valid;
            if (in_valid)
                y_d = cell_f;
        end else begin
            y_d = '0;
        end
    end

    // NOTE: state is updated only with non-blocking assignments. Every
    // register then samples the values from before the edge, whatever
    // order the statements appear in.
    // NOTE: the key register sits on the async reset like every other
    // flop. After reset, a half-loaded key can never select a function.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            cnt_q       <= cnt_d;
            par_q       <= par_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign key_ready = (state_q == S_LOAD);
    assign armed     = (state_q == S_ARMED);
    assign key_err   = (state_q == S_ERROR);
    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_camo_cell_array.sv
// ---------------------------------------------------------------------------
// tb_camo_cell_array
//
// Directed bench for camo_cell_array (NCELL = 8). The stimulus process
// pushes each hand-computed y into a queue when it issues an operand pair.
// A separate monitor pops one entry and compares it whenever the DUT shows
// out_valid. Control outputs (armed, key_err, key_ready) and the reset
// behaviour are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_camo_cell_array;

    localparam int NCELL = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             key_start = 1'b0;
    logic             key_valid = 1'b0;
    logic             key_ready;
    logic             key_bit = 1'b0;
    logic             key_last = 1'b0;
    logic             in_valid = 1'b0;
    logic [NCELL-1:0] a = '0;
    logic [NCELL-1:0] b = '0;
    logic             out_valid;
    logic [NCELL-1:0] y;
    logic             armed;
    logic             key_err;

    int checks   = 0;
    int failures = 0;
    logic [NCELL-1:0] exp_q[$];

    camo_cell_array #(.NCELL(NCELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_bit   (key_bit),
        .key_last  (key_last),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y),
        .armed     (armed),
        .key_err   (key_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each presented output with the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    logic [NCELL-1:0] e;
                    e = exp_q.pop_front();
                    check("y_scoreboard", 32'(y), 32'(e));
                end
            end
        end
    end

    // All input changes happen 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        // The coincident key_valid bit must be discarded.
        key_start = 1'b1;
        key_valid = 1'b1;
        key_bit   = 1'b1;
        tick();
        key_start = 1'b0;
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    task automatic send_bit(input logic bv, input logic last);
        key_valid = 1'b1;
        key_bit   = bv;
        key_last  = last;
        tick();
        key_valid = 1'b0;
        key_last  = 1'b0;
    endtask

    // Full load: start, 16 key bits, then the parity bit with key_last.
    // A gap of gap_len idle cycles is inserted before bit gap_at. The task
    // returns one cycle after the transfer, once CHECK has resolved.
    task automatic load_key(input logic [15:0] k, input logic par,
                            input int gap_at, input int gap_len);
        pulse_start();
        check("key_ready_in_load", 32'(key_ready), 32'd1);
        for (int i = 0; i <= 16; i++) begin
            if (i == gap_at)
                repeat (gap_len) tick();
            if (i < 16) send_bit(k[i], 1'b0);
            else        send_bit(par, 1'b1);
        end
        tick();
    endtask

    task automatic issue(input logic [NCELL-1:0] av, input logic [NCELL-1:0] bv,
                         input logic [NCELL-1:0] exp);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key_ready"}, 32'(key_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_y"},         32'(y),         32'd0);
        check({tag, "_armed"},     32'(armed),     32'd0);
        check({tag, "_key_err"},   32'(key_err),   32'd0);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // All NAND: key 0x0000, parity 0
        load_key(16'h0000, 1'b0, -1, 0);
        check("nand_armed", 32'(armed), 32'd1);
        check("nand_key_err", 32'(key_err), 32'd0);
        issue(8'hF0, 8'hCC, 8'h3F);
        tick();
        check("y_hold_value", 32'(y), 32'h3F);
        check("y_hold_out_valid", 32'(out_valid), 32'd0);

        // All NOR: key 0xAAAA
        load_key(16'hAAAA, 1'b0, -1, 0);
        check("nor_armed", 32'(armed), 32'd1);
        issue(8'hF0, 8'hCC, 8'h03);

        // All XOR: key 0x5555
        load_key(16'h5555, 1'b0, -1, 0);
        check("xor_armed", 32'(armed), 32'd1);
        issue(8'hF0, 8'hCC, 8'h3C);

        // Mixed 0x0012: cell0 NOR, cell2 XOR, others NAND
        load_key(16'h0012, 1'b0, -1, 0);
        check("mixed_armed", 32'(armed), 32'd1);
        issue(8'h01, 8'h00, 8'hFA);
        issue(8'hF0, 8'hCC, 8'h3F);
        tick();

        // Bad parity: 0x5555 with parity 1
        load_key(16'h5555, 1'b1, -1, 0);
        check("parity_key_err", 32'(key_err), 32'd1);
        check("parity_armed", 32'(armed), 32'd0);
        a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        check("parity_out_valid", 32'(out_valid), 32'd0);
        check("parity_y", 32'(y), 32'd0);
        pulse_start();
        check("start_clears_key_err", 32'(key_err), 32'd0);
        check("start_enters_load", 32'(key_ready), 32'd1);

        // key_last on bit 7
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        check("early_last_key_err", 32'(key_err), 32'd1);
        check("early_last_armed", 32'(armed), 32'd0);

        // 17th bit without key_last
        pulse_start();
        for (int i = 0; i < 16; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        check("no_last_key_err", 32'(key_err), 32'd1);

        // Gap of 5 idle cycles in the middle of a load
        load_key(16'h0012, 1'b0, 8, 5);
        check("gap_armed", 32'(armed), 32'd1);
        issue(8'h01, 8'h00, 8'hFA);

        // Restart from LOAD: junk bits, then a full load of 0x5555
        pulse_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        load_key(16'h5555, 1'b0, -1, 0);
        check("restart_armed", 32'(armed), 32'd1);

        // key_start while ARMED with in_valid high: the last armed operand
        // emits, then out_valid drops.
        a = 8'hF0; b = 8'hCC; in_valid = 1'b1; key_start = 1'b1;
        exp_q.push_back(8'h3C);
        tick();
        key_start = 1'b0;
        a = 8'h0F;
        check("restart_armed_falls", 32'(armed), 32'd0);
        check("last_operand_emits", 32'(out_valid), 32'd1);
        tick();
        check("out_valid_dropped", 32'(out_valid), 32'd0);
        check("y_cleared", 32'(y), 32'd0);
        in_valid = 1'b0;

        // Async reset in LOAD
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_in_load");
        tick();
        rst = 1'b0;
        tick();

        // Async reset in ARMED while y is non-zero
        load_key(16'h0000, 1'b0, -1, 0);
        check("rst_armed_pre", 32'(armed), 32'd1);
        issue(8'hF0, 8'hCC, 8'h3F);
        @(negedge clk);
        #1 check("rst_armed_y_before", 32'(y), 32'h3F);
        rst = 1'b1;
        #1 check_all_zero("rst_in_armed");
        tick();
        rst = 1'b0;
        tick();

        // Wait for the scoreboard to drain, with a bound on the wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
